// File: rtl/sssp_pkg.sv
// sssp_pkg: shared edge-word layout, unreachable-distance constant and job FSM states
package sssp_pkg;
    localparam int PARENT_LSB = 0;
    localparam int CHILD_LSB  = 4;
    localparam int WEIGHT_LSB = 8;
    localparam int EDGE_W     = 12;
    localparam logic [63:0] DIST_INF = '1;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN} state_t;
endpackage

// File: rtl/sssp_edge_ram.sv
// sssp_edge_ram: edge store with one write port and one independent registered read port
module sssp_edge_ram #(
    parameter int AW = 8,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    // write port: contents carry no reset
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    // read port: one-cycle latency, output register cleared by reset
    always_ff @(posedge clk)
        rdata <= !reset ? '0 : mem[raddr];
endmodule

// File: rtl/sssp_job_ctrl.sv
// sssp_job_ctrl: job sequencer (header, edge load, engine run, result drain); optional RUN watchdog via WATCHDOG_EN
module sssp_job_ctrl
    import sssp_pkg::*;
#(
    parameter int NODE_W  = 4,
    parameter int EDGE_AW = 8,
    parameter int WT_W    = 4,
    parameter int DIST_W  = 16
`ifdef WATCHDOG_EN
    , parameter int WDOG_CYCLES = 4096
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [NODE_W-1:0]  cfg_nodes,
    input  logic [EDGE_AW-1:0] cfg_edges,
    input  logic               edge_valid,
    output logic               edge_ready,
    input  logic [EDGE_W-1:0]  edge_data,
    output logic               eng_start,
    output logic [NODE_W-1:0]  eng_nodes,
    output logic [EDGE_AW-1:0] eng_edges,
    input  logic [EDGE_AW-1:0] eng_rd_addr,
    output logic [EDGE_W-1:0]  eng_rd_data,
    input  logic               eng_wr_en,
    input  logic [NODE_W-1:0]  eng_wr_addr,
    input  logic [DIST_W-1:0]  eng_wr_data,
    input  logic               eng_done,
    input  logic               hold,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [NODE_W-1:0]  res_node,
    output logic [DIST_W-1:0]  res_dist,
    output logic               res_last,
    output logic               err_range,
    output logic               job_done
`ifdef WATCHDOG_EN
    , output logic             err_timeout
`endif
);
    state_t             state_q;
    logic [NODE_W-1:0]  nodes_q, idx_q;
    logic [EDGE_AW-1:0] edges_q, edge_cnt_q;
    logic [DIST_W-1:0]  dist_q [2**NODE_W];
    logic               err_range_q, job_done_q;
    logic               cfg_acc, edge_acc, edge_bad, wr_ok, drain, res_acc;
`ifdef WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
    logic [WDW-1:0] wdog_q;
    logic           err_timeout_q;
    assign err_timeout = err_timeout_q;
`endif

    assign cfg_ready  = state_q == S_IDLE;
    assign edge_ready = state_q == S_LOAD;
    assign eng_start  = state_q == S_START;
    assign drain      = state_q == S_DRAIN;
    assign eng_nodes  = nodes_q;
    assign eng_edges  = edges_q;
    assign err_range  = err_range_q;
    assign job_done   = job_done_q;
    assign cfg_acc    = cfg_valid && cfg_ready;
    assign edge_acc   = edge_valid && edge_ready;
    assign edge_bad   = edge_data[PARENT_LSB +: NODE_W] > nodes_q || edge_data[CHILD_LSB +: NODE_W] > nodes_q;
    assign wr_ok      = state_q == S_RUN && eng_wr_en && eng_wr_addr <= nodes_q;
    assign res_valid  = drain && !hold;
    assign res_acc    = res_valid && res_ready;
    assign res_node   = drain ? idx_q : '0;
    assign res_dist   = drain ? dist_q[idx_q] : '0;
    assign res_last   = drain && idx_q == nodes_q;

    sssp_edge_ram #(.AW(EDGE_AW), .DW(WEIGHT_LSB + WT_W)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (edge_acc),
        .waddr (edge_cnt_q),
        .wdata (edge_data),
        .raddr (eng_rd_addr),
        .rdata (eng_rd_data)
    );

    // distance buffer: unreachable on reset and on each new job, engine writes land only in RUN
    always_ff @(posedge clk)
        if (!reset || cfg_acc)
            for (int i = 0; i < 2**NODE_W; i++) dist_q[i] <= DIST_W'(DIST_INF);
        else if (wr_ok)
            dist_q[eng_wr_addr] <= eng_wr_data;

    // job sequencer: header accept, edge load, start pulse, run, result drain
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            nodes_q     <= '0;
            edges_q     <= '0;
            edge_cnt_q  <= '0;
            idx_q       <= '0;
            err_range_q <= 1'b0;
            job_done_q  <= 1'b0;
`ifdef WATCHDOG_EN
            wdog_q        <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            job_done_q <= 1'b0;
            case (state_q)
                S_IDLE:
                    if (cfg_valid) begin
                        nodes_q     <= cfg_nodes;
                        edges_q     <= cfg_edges;
                        edge_cnt_q  <= '0;
                        idx_q       <= '0;
                        err_range_q <= 1'b0;
`ifdef WATCHDOG_EN
                        err_timeout_q <= 1'b0;
`endif
                        state_q <= cfg_edges != '0 ? S_LOAD : S_START;
                    end
                S_LOAD:
                    if (edge_valid) begin
                        edge_cnt_q <= edge_cnt_q + EDGE_AW'(1);
                        if (edge_bad) err_range_q <= 1'b1;
                        if (edge_cnt_q == edges_q - EDGE_AW'(1)) state_q <= S_START;
                    end
                S_START: begin
                    state_q <= S_RUN;
`ifdef WATCHDOG_EN
                    wdog_q <= '0;
`endif
                end
                S_RUN:
`ifdef WATCHDOG_EN
                    if (eng_done)
                        state_q <= S_DRAIN;
                    else if (wdog_q == WDOG_LAST) begin
                        state_q       <= S_DRAIN;
                        err_timeout_q <= 1'b1;
                    end else
                        wdog_q <= wdog_q + WDW'(1);
`else
                    if (eng_done) state_q <= S_DRAIN;
`endif
                S_DRAIN:
                    if (res_acc) begin
                        idx_q <= idx_q + NODE_W'(1);
                        if (idx_q == nodes_q) begin
                            state_q    <= S_IDLE;
                            job_done_q <= 1'b1;
                        end
                    end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
